// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 read-cycle engine with optional busy-flag polling.
// Defining LCD_READER_TIMEOUT_EN bounds a poll to TIMEOUT busy reads.
module lcd_reader #(
  parameter int T_AS = 3,
  parameter int T_EH = 23,
  parameter int T_EL = 25
`ifdef LCD_READER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 1000
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_rs,
  input  logic       i_poll,
  input  logic [7:0] i_lcd_data,
  output logic       o_E,
  output logic       o_RS,
  output logic       o_RW,
  output logic       o_drive_n,
  output logic       o_busy,
  output logic       o_valid,
  output logic [7:0] o_rdata,
  output logic       o_bf,
  output logic       o_timeout
);

  localparam int T_MAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                       : ((T_EH > T_EL) ? T_EH : T_EL);
  localparam int CW = $clog2(T_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, EHIGH, EHOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          rs_q, poll_q;
  logic          accept, setup_done, ehigh_done, ehold_done;
  logic          to_hit, repoll, finish;

  assign accept     = (state == IDLE) && i_req;
  assign setup_done = (state == SETUP) && (cnt == CW'(T_AS - 1));
  assign ehigh_done = (state == EHIGH) && (cnt == CW'(T_EH - 1));
  assign ehold_done = (state == EHOLD) && (cnt == CW'(T_EL - 1));
  // Another SETUP only while polling, the controller is still busy and the budget is not spent.
  assign repoll     = ehold_done && poll_q && o_rdata[7] && !to_hit;
  assign finish     = ehold_done && !repoll;

`ifdef LCD_READER_TIMEOUT_EN
  localparam int PW = $clog2(TIMEOUT + 1);
  logic [PW-1:0] poll_cnt;
  logic          timeout_q;

  assign to_hit    = (poll_cnt == PW'(TIMEOUT - 1));
  assign o_timeout = timeout_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      poll_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (repoll && poll_cnt != {PW{1'b1}})
        poll_cnt <= poll_cnt + 1'b1;
      if (finish)
        timeout_q <= poll_q && o_rdata[7] && to_hit;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_req)      state_nx = SETUP;
      SETUP:   if (setup_done) state_nx = EHIGH;
      EHIGH:   if (ehigh_done) state_nx = EHOLD;
      EHOLD: begin
        if (finish)      state_nx = IDLE;
        else if (repoll) state_nx = SETUP;
      end
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_E    = 1'b0;
    o_RS   = 1'b0;
    o_RW   = 1'b0;
    o_busy = 1'b0;
    if (state != IDLE) begin
      o_RS   = rs_q;
      o_RW   = 1'b1;
      o_busy = 1'b1;
    end
    if (state == EHIGH) o_E = 1'b1;
  end

  assign o_drive_n = o_RW;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      rs_q    <= 1'b0;
      poll_q  <= 1'b0;
      o_valid <= 1'b0;
      o_rdata <= 8'h00;
      o_bf    <= 1'b0;
    end else begin
      o_valid <= finish;
      if (state == IDLE || state_nx != state) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
      if (accept) begin
        rs_q   <= i_rs;
        poll_q <= i_poll & ~i_rs;
      end
      if (ehigh_done) begin
        o_rdata <= i_lcd_data;
        o_bf    <= ~rs_q & i_lcd_data[7];
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - randomized and directed checks of lcd_reader against a read-sequence model.
module tb_lcd_reader;
  localparam int T_AS = 3;
  localparam int T_EH = 23;
  localparam int T_EL = 25;
  localparam int PER  = T_AS + T_EH + T_EL;
`ifdef LCD_READER_TIMEOUT_EN
  localparam int TMO  = 4;
`endif

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_req = 1'b0;
  logic       i_rs = 1'b0;
  logic       i_poll = 1'b0;
  logic [7:0] i_lcd_data = 8'h00;
  logic       o_E, o_RS, o_RW, o_drive_n, o_busy, o_valid, o_bf, o_timeout;
  logic [7:0] o_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] bus_vals [16];

  lcd_reader #(
    .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL)
`ifdef LCD_READER_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_rs(i_rs), .i_poll(i_poll),
    .i_lcd_data(i_lcd_data), .o_E(o_E), .o_RS(o_RS), .o_RW(o_RW),
    .o_drive_n(o_drive_n), .o_busy(o_busy), .o_valid(o_valid),
    .o_rdata(o_rdata), .o_bf(o_bf), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: a read sequence is the list of bytes the LCD presents, one per E pulse.
  task automatic run_txn(input string name, input logic rs, input logic poll,
                         input int nbus, input int req_hold, input bit b2b);
    int reads = 1;
    int exp_valid;
    logic [7:0] exp_rd;
    logic exp_bf;
    logic exp_to = 1'b0;
    int pulses = 0, vcount = 0, vcyc = -1, first_e = -1, last_e = -1, idx = 0, stab_err = 0;
    logic prev_e = 1'b0, rs_rise = 1'b0, rw_rise = 1'b0;

    if (poll && !rs) begin
      reads = nbus;
      for (int i = 0; i < nbus; i++)
        if (!bus_vals[i][7]) begin
          reads = i + 1;
          break;
        end
`ifdef LCD_READER_TIMEOUT_EN
      if (reads > TMO) reads = TMO;
      exp_to = bus_vals[reads-1][7];
`endif
    end
    exp_valid = reads * PER + 1;
    exp_rd    = bus_vals[reads-1];
    exp_bf    = !rs && exp_rd[7];

    @(negedge i_clk);
    i_rs = rs; i_poll = poll; i_req = 1'b1; i_lcd_data = bus_vals[0];
    @(posedge i_clk);
    for (int c = 1; c <= exp_valid + 3; c++) begin
      @(negedge i_clk);
      if (c == 1) begin
        chk({name, " busy@1"}, o_busy, 1);
        chk({name, " rw@1"}, o_RW, 1);
        chk({name, " rs@1"}, o_RS, rs);
      end
      if (o_E && !prev_e) begin
        pulses++;
        rs_rise = o_RS;
        rw_rise = o_RW;
        if (first_e < 0) first_e = c;
      end
      if (o_E && (o_RS !== rs_rise || o_RW !== rw_rise)) stab_err++;
      if (o_drive_n !== o_RW) stab_err++;
      if (o_E) last_e = c;
      if (!o_E && prev_e) begin
        if (idx < nbus - 1) idx++;
        i_lcd_data = bus_vals[idx];
      end
      prev_e = o_E;
      if (o_valid) begin
        vcount++;
        if (vcyc < 0) vcyc = c;
        chk({name, " rdata"}, o_rdata, exp_rd);
        chk({name, " bf"}, o_bf, exp_bf);
        chk({name, " timeout"}, o_timeout, exp_to);
        chk({name, " busy@valid"}, o_busy, 0);
        chk({name, " rw@valid"}, o_RW, 0);
      end
      if (b2b && c == exp_valid + 1) begin
        chk({name, " b2b rw"}, o_RW, 1);
        chk({name, " b2b busy"}, o_busy, 1);
      end
      if (c >= req_hold && !(b2b && c <= exp_valid)) i_req = 1'b0;
    end
    chk({name, " pulses"}, pulses, reads);
    chk({name, " valid cycle"}, vcyc, exp_valid);
    chk({name, " valid count"}, vcount, 1);
    chk({name, " first E"}, first_e, T_AS + 1);
    chk({name, " last E"}, last_e, exp_valid - 1 - T_EL);
    chk({name, " stability"}, stab_err, 0);
  endtask

  initial begin
    int vc;
    int w;
    int nbf;
    logic r_rs, r_poll;

    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset E/RS/RW", {o_E, o_RS, o_RW, o_drive_n}, 0);
    chk("reset busy/valid", {o_busy, o_valid}, 0);
    chk("reset data", {o_rdata, o_bf, o_timeout}, 0);

    // Reset in the middle of the E-high phase.
    i_rs = 1'b1; i_poll = 1'b0; i_req = 1'b1; i_lcd_data = 8'h11;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("pre-reset E", o_E, 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst E", o_E, 0);
    chk("rst RW", o_RW, 0);
    chk("rst busy", o_busy, 0);
    vc = 0;
    for (int c = 0; c < 60; c++) begin
      if (o_valid) vc++;
      @(negedge i_clk);
    end
    chk("rst no valid", vc, 0);

    bus_vals[0] = 8'hA5;
    run_txn("data read", 1'b1, 1'b0, 1, 1, 1'b0);
    bus_vals[0] = 8'h8C;
    run_txn("status read", 1'b0, 1'b0, 1, 1, 1'b0);
    bus_vals[0] = 8'h80; bus_vals[1] = 8'h80; bus_vals[2] = 8'h80; bus_vals[3] = 8'h05;
    run_txn("poll", 1'b0, 1'b1, 4, 1, 1'b0);
`ifdef LCD_READER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) bus_vals[i] = 8'hFF;
    run_txn("poll timeout", 1'b0, 1'b1, 4, 1, 1'b0);
`endif
    bus_vals[0] = 8'h42;
    run_txn("req while busy", 1'b1, 1'b0, 1, 20, 1'b0);

    bus_vals[0] = 8'h5A;
    run_txn("back to back", 1'b1, 1'b0, 1, 1, 1'b1);
    i_lcd_data = 8'h3C;
    w = 0;
    while (!o_valid && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    chk("b2b second valid wait", w, PER + 1 - 3);
    chk("b2b second rdata", o_rdata, 8'h3C);

    for (int t = 0; t < 6; t++) begin
      r_rs   = 1'($urandom_range(0, 1));
      r_poll = 1'($urandom_range(0, 1));
      nbf    = (r_poll && !r_rs) ? $urandom_range(0, 3) : 0;
      for (int i = 0; i < nbf; i++) bus_vals[i] = 8'h80 | 8'($urandom_range(0, 127));
      bus_vals[nbf] = (r_poll && !r_rs) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255));
      run_txn($sformatf("random %0d", t), r_rs, r_poll, nbf + 1, 1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the HD44780-style character-LCD writer: it runs read cycles (RW=1) on the 8-bit LCD bus, returning either the busy flag plus address counter (RS=0) or a display/CG RAM byte (RS=1). An optional poll mode repeats busy-flag reads until the controller reports ready, so the writer can be gated on real LCD status instead of fixed delays. Sits beside the writer in the display subsystem; the top level muxes E/RS/RW and the bus direction between the two using `o_drive_n`.

## Interface
- `T_AS`, 3: cycles of RS/RW setup before E rises (min 1)
- `T_EH`, 23: cycles E is held high; data sampled on the last one (min 1)
- `T_EL`, 25: cycles E is held low after the falling edge, before completion or the next poll (min 1)
- `TIMEOUT`, 1000: max busy-flag reads in one poll request (used only with the macro)
- `i_clk`  in  1  system clock
- `i_rst`  in  1  reset; synchronous, active-high
- `i_req`  in  1  start a read; accepted only in IDLE
- `i_rs`  in  1  register select for the read; sampled on acceptance
- `i_poll`  in  1  repeat BF reads until BF=0; sampled on acceptance, honoured only with `i_rs`=0
- `i_lcd_data`  in  8  LCD DB[7:0] as seen at the pad
- `o_E`  out  1  LCD enable
- `o_RS`  out  1  LCD register select
- `o_RW`  out  1  LCD read/write; 1 only during a transaction
- `o_drive_n`  out  1  1 = FPGA must tri-state DB[7:0]; equals `o_RW`
- `o_busy`  out  1  transaction in progress
- `o_valid`  out  1  one-cycle pulse: result valid
- `o_rdata`  out  8  last sampled byte
- `o_bf`  out  1  `o_rdata[7]` when the read had RS=0, else 0
- `o_timeout`  out  1  poll ended by timeout; valid with `o_valid`

## Operation
- All outputs reset to 0; state IDLE; counters 0.
- States: IDLE, SETUP, EHIGH, EHOLD.
- IDLE: `o_RW`=0, `o_E`=0. `i_req`=1 latches `i_rs`, `i_poll & ~i_rs` → SETUP; `o_RS` = latched rs, `o_RW`=1 from the next cycle.
- SETUP: `o_E`=0 for `T_AS` cycles → EHIGH.
- EHIGH: `o_E`=1 for `T_EH` cycles; on the last one `i_lcd_data` is registered into `o_rdata` → EHOLD.
- EHOLD: `o_E`=0 for `T_EL` cycles, then:
  - not poll, or `o_rdata[7]`=0 → IDLE with `o_valid`=1 for one cycle;
  - poll and BF=1 → SETUP, with the poll count incremented.
- `o_rdata`, `o_bf` and `o_timeout` hold until the next sample/completion. `o_timeout` clears on acceptance of a new request.
- `i_req` outside IDLE is ignored (no queueing); `i_req` high during the `o_valid` cycle is accepted, since that cycle is IDLE.
- `i_rst` during any state: next edge returns IDLE, `o_E`=0, `o_RW`=0, and there is no `o_valid` pulse.
- Phase counter width is `$clog2(max(T_AS,T_EH,T_EL)+1)`. The poll counter saturates and never wraps.

## Timing
- Request accepted at edge 0; `o_busy`=1 and `o_RW`=1 from cycle 1.
- Cycles 1..T_AS are setup; E is high for T_AS+1..T_AS+T_EH.
- Single read: `o_valid` and `o_busy`=0 in cycle N = T_AS+T_EH+T_EL+1 (defaults: N=52).
- Poll of k reads: `o_valid` in cycle k·(T_AS+T_EH+T_EL)+1.
- `o_RS`/`o_RW` stay stable while `o_E`=1 and change only in IDLE or SETUP.

## Configuration
- `LCD_READER_TIMEOUT_EN` defined: a poll aborts after `TIMEOUT` reads that all returned BF=1.
  - It completes to IDLE with `o_valid`=1, `o_timeout`=1, and `o_rdata` = last sample.
- Undefined: poll continues until BF=0. `o_timeout` is tied 0 and the poll counter is removed.

## Test plan
- Reset mid-EHIGH (`i_rst` high one cycle) → next cycle `o_E`=0, `o_RW`=0, `o_busy`=0, and there is no `o_valid`.
- Single data read: `i_rs`=1, `i_lcd_data`=0xA5 → `o_E` high in cycles 4..26, `o_valid` in cycle 52, `o_rdata`=0xA5, `o_bf`=0.
- Status read without poll: `i_rs`=0, `i_lcd_data`=0x8C → `o_valid` in cycle 52, `o_bf`=1, `o_rdata`=0x8C, one E pulse.
- Poll: the bus model returns 0x80 for 3 reads, then 0x05 → 4 E pulses, `o_valid` in cycle 205, `o_rdata`=0x05, `o_bf`=0, `o_timeout`=0.
- Poll timeout (macro defined, `TIMEOUT`=4, bus held at 0xFF) → exactly 4 E pulses, then `o_valid`=1 and `o_timeout`=1.
- Repeated `i_req` while `o_busy` → ignored, one `o_valid` only.
- Back-to-back reads: `i_req` held high → next transaction accepted in the `o_valid` cycle, and `o_RW` stays 1 only from the following cycle on.
